pipe_scheduler: RTL

Sequencer for the scrolling pipe-column shifter chain on the 16-row LED matrix. It divides clkM into a scroll-tick strobe and decides which ticks inject a new pipe column. It generates the injected column pattern, with a pseudo-random gap, from an LFSR. It freezes the playfield on gameover and restarts on start; the shifter columns consume shift_en / spawn / newPipe directly.

---
 rtl/pipe_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipe_scheduler.sv
// pipe_scheduler
//   Scroll sequencer for the pipe-column shifter chain of the 16-row LED matrix.
//   It divides clkM into a one-cycle scroll strobe and marks every PIPE_SPACING-th
//   strobe as a spawn. It also presents the next pipe column, whose gap position
//   comes from an 8-bit LFSR that steps once per spawn.
//
// Ports
//   clkM        in   system clock
//   reset       in   synchronous, active-high reset
//   start       in   level, begins play from IDLE or resumes from HALT
//   gameover    in   level from collision logic, freezes the playfield
//   speed[1:0]  in   tick period = SHIFT_DIV >> speed, sampled at each reload
//   shift_en    out  one-cycle scroll strobe
//   spawn       out  one-cycle injection pulse, only together with shift_en
//   newPipe     out  pending column, bit i = row i, 1 = pipe, 0 = gap
//   gap_row     out  lowest gap row of the pending column (1..11)
//   pipe_count  out  pipes spawned since play (re)started, saturating at 255
//   state       out  00 IDLE, 01 RUN, 10 HALT
module pipe_scheduler #(
  parameter int unsigned SHIFT_DIV    = 8,
  parameter int unsigned PIPE_SPACING = 3,
  parameter int unsigned GAP_H        = 4,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        clkM,
  input  logic        reset,
  input  logic        start,
  input  logic        gameover,
  input  logic [1:0]  speed,
  output logic        shift_en,
  output logic        spawn,
  output logic [15:0] newPipe,
  output logic [3:0]  gap_row,
  output logic [7:0]  pipe_count,
  output logic [1:0]  state
);

  localparam int PW = $clog2(SHIFT_DIV + 1);
  localparam int SW = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
  localparam logic [7:0]    SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [SW-1:0] SPACE_LAST = SW'(PIPE_SPACING - 1);
  // Number of legal gap positions' wrap point: rows 1..(16-GAP_H-1) as lowest gap row.
  localparam logic [3:0]    GAP_MOD    = 4'(16 - GAP_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] period_q, period_d;
  logic [SW-1:0] space_q, space_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    count_q, count_d;
  logic [15:0]   newpipe_q, newpipe_d;
  logic [3:0]    gap_q, gap_d;

  logic [31:0]   div_full;
  logic [PW-1:0] reload_val;
  logic          tick;
  logic [7:0]    pat_src;
  logic [3:0]    gap_raw;
  logic [3:0]    gap_top;

  // Period for the next scroll interval. SHIFT_DIV>>3 can reach 1, which would
  // strobe every cycle; the floor of 2 keeps shift_en from ever being high on
  // two consecutive cycles.
  assign div_full   = SHIFT_DIV >> speed;
  assign reload_val = (div_full < 32'd2) ? PW'(2) : div_full[PW-1:0];

  assign tick     = (state_q == RUN) && (presc_q == period_q - PW'(1));
  // gameover and reset both suppress a tick that falls in the same cycle.
  assign shift_en = tick && !gameover && !reset;
  assign spawn    = shift_en && (space_q == SPACE_LAST);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    period_d = period_q;
    space_d  = space_q;
    lfsr_d   = lfsr_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        space_d = '0;
        if (start) begin
          state_d  = RUN;
          count_d  = 8'd0;
          period_d = reload_val;
        end
      end
      RUN: begin
        if (gameover) begin
          // Everything freezes where it is; resume clears the counters anyway.
          state_d = HALT;
        end else if (tick) begin
          presc_d  = '0;
          period_d = reload_val;
          if (space_q == SPACE_LAST) begin
            space_d = '0;
            lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          end else begin
            space_d = space_q + SW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      HALT: begin
        if (start && !gameover) begin
          state_d  = RUN;
          presc_d  = '0;
          space_d  = '0;
          count_d  = 8'd0;
          period_d = reload_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkM) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      period_q <= PW'(SHIFT_DIV);
      space_q  <= '0;
      lfsr_q   <= SEED;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      period_q <= period_d;
      space_q  <= space_d;
      lfsr_q   <= lfsr_d;
      count_q  <= count_d;
    end
  end

  // The column pattern is derived from the *next* LFSR value so the registered
  // pattern always matches lfsr_q: it holds steady through a spawn and shows the
  // new column on the cycle right after it.
  assign pat_src = reset ? SEED : lfsr_d;
  assign gap_raw = (pat_src[3:0] >= GAP_MOD) ? pat_src[3:0] - GAP_MOD : pat_src[3:0];
  assign gap_d   = gap_raw + 4'd1;
  assign gap_top = gap_d + 4'(GAP_H - 1);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_row
      assign newpipe_d[gi] = !((4'(gi) >= gap_d) && (4'(gi) <= gap_top));
    end
  endgenerate

  always_ff @(posedge clkM) begin
    newpipe_q <= newpipe_d;
    gap_q     <= gap_d;
  end

  assign newPipe    = newpipe_q;
  assign gap_row    = gap_q;
  assign pipe_count = count_q;
  assign state      = state_q;

endmodule
